// File: rtl/touch_adc_ctrl_pkg.sv
// rtl/touch_adc_ctrl_pkg.sv - shared state type and frame constants for the touch ADC controller
package touch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FRAME_X,
        FRAME_Y,
        UPDATE,
        GAP
    } state_e;

    localparam logic [7:0] CMD_X      = 8'hD8;
    localparam logic [7:0] CMD_Y      = 8'h98;
    localparam int         FRAME_LEN  = 24;
    localparam int         DATA_FIRST = 10;
    localparam int         DATA_LAST  = 17;

endpackage

// File: rtl/touch_adc_ctrl_if.sv
// rtl/touch_adc_ctrl_if.sv - serial pin bundle between the controller and the touch ADC
interface touch_adc_ctrl_if;

    logic adc_penirq_n;
    logic adc_dout;
    logic adc_busy;
    logic adc_cs_n;
    logic adc_dclk;
    logic adc_din;

    modport master (
        input  adc_penirq_n,
        input  adc_dout,
        input  adc_busy,
        output adc_cs_n,
        output adc_dclk,
        output adc_din
    );

    modport slave (
        output adc_penirq_n,
        output adc_dout,
        output adc_busy,
        input  adc_cs_n,
        input  adc_dclk,
        input  adc_din
    );

endinterface

// File: rtl/touch_spi_frame.sv
// rtl/touch_spi_frame.sv - one 24-clock ADC frame: shifts the command out and the 8-bit result in
module touch_spi_frame
    import touch_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] cmd_i,
    input  logic       dout_i,
    output logic       cs_n_o,
    output logic       dclk_o,
    output logic       din_o,
    output logic [7:0] result_o,
    output logic       done_o
);

    typedef enum logic [1:0] {F_IDLE, F_SHIFT, F_TAIL} phase_e;

    localparam int             DIV_W     = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] HALF_END = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] TAIL_END = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [4:0]     BIT_LAST  = 5'(FRAME_LEN - 1);
    localparam logic [4:0]     SAMPLE_LO = 5'(DATA_FIRST - 1);
    localparam logic [4:0]     SAMPLE_HI = 5'(DATA_LAST - 1);

    phase_e           phase_q;
    logic [DIV_W-1:0] div_q;
    logic [4:0]       bit_q;
    logic             cs_n_q, dclk_q, din_q, done_q;
    logic [7:0]       cmd_q, res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= F_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            cs_n_q  <= 1'b1;
            dclk_q  <= 1'b0;
            din_q   <= 1'b0;
            done_q  <= 1'b0;
            cmd_q   <= '0;
            res_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (phase_q)
                F_IDLE: begin
                    if (start_i) begin
                        // first command bit must be on din before the first rising dclk
                        phase_q <= F_SHIFT;
                        cs_n_q  <= 1'b0;
                        din_q   <= cmd_i[7];
                        cmd_q   <= {cmd_i[6:0], 1'b0};
                        div_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                F_SHIFT: begin
                    if (div_q != HALF_END) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q <= '0;
                        if (!dclk_q) begin
                            dclk_q <= 1'b1;
                            if (bit_q >= SAMPLE_LO && bit_q <= SAMPLE_HI) begin
                                res_q <= {res_q[6:0], dout_i};
                            end
                        end else begin
                            dclk_q <= 1'b0;
                            if (bit_q == BIT_LAST) begin
                                phase_q <= F_TAIL;
                                cs_n_q  <= 1'b1;
                                din_q   <= 1'b0;
                            end else begin
                                bit_q <= bit_q + 5'd1;
                                din_q <= cmd_q[7];
                                cmd_q <= {cmd_q[6:0], 1'b0};
                            end
                        end
                    end
                end
                F_TAIL: begin
                    if (div_q != TAIL_END) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q   <= '0;
                        phase_q <= F_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: phase_q <= F_IDLE;
            endcase
        end
    end

    assign cs_n_o   = cs_n_q;
    assign dclk_o   = dclk_q;
    assign din_o    = din_q;
    assign result_o = res_q;
    assign done_o   = done_q;

endmodule

// File: rtl/touch_adc_ctrl.sv
// rtl/touch_adc_ctrl.sv - touch ADC sequencer: pen detect, X/Y frame pairs, coordinate update and gap
module touch_adc_ctrl
    import touch_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int GAP_CYC = 4096
) (
    input  logic              sys_clk,
    input  logic              iRST_n,
    touch_adc_ctrl_if.master  adc,
    output logic [7:0]        x,
    output logic [7:0]        y,
    output logic              new_coord_r,
    output logic              penirq_n,
    output logic              transmit_en
);

    localparam int               GAP_W   = $clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(GAP_CYC);

    logic             pen_s1_q, pen_s2_q, dout_s1_q, dout_s2_q, penirq_q;
    state_e           state_q;
    logic             start_q, new_q, tx_q;
    logic [7:0]       hold_x_q, hold_y_q, x_q, y_q;
    logic [GAP_W-1:0] gap_q;
    logic             frame_cs_n, frame_done;
    logic [7:0]       frame_result, frame_cmd;

    assign frame_cmd = (state_q == FRAME_Y) ? CMD_Y : CMD_X;

    touch_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
        .clk      (sys_clk),
        .rst_n    (iRST_n),
        .start_i  (start_q),
        .cmd_i    (frame_cmd),
        .dout_i   (dout_s2_q),
        .cs_n_o   (frame_cs_n),
        .dclk_o   (adc.adc_dclk),
        .din_o    (adc.adc_din),
        .result_o (frame_result),
        .done_o   (frame_done)
    );

    assign adc.adc_cs_n = frame_cs_n;

    // penirq is frozen during a frame because the ADC disturbs its pen line while converting
    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            pen_s1_q  <= 1'b1;
            pen_s2_q  <= 1'b1;
            dout_s1_q <= 1'b0;
            dout_s2_q <= 1'b0;
            penirq_q  <= 1'b1;
        end else begin
            pen_s1_q  <= adc.adc_penirq_n;
            pen_s2_q  <= pen_s1_q;
            dout_s1_q <= adc.adc_dout;
            dout_s2_q <= dout_s1_q;
            if (frame_cs_n) penirq_q <= pen_s2_q;
        end
    end

    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            new_q    <= 1'b0;
            tx_q     <= 1'b0;
            hold_x_q <= '0;
            hold_y_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            gap_q    <= '0;
        end else begin
            start_q <= 1'b0;
            new_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!pen_s2_q) begin
                        state_q <= FRAME_X;
                        start_q <= 1'b1;
                        tx_q    <= 1'b1;
                    end
                end
                FRAME_X: begin
                    if (frame_done) begin
                        hold_x_q <= frame_result;
                        state_q  <= FRAME_Y;
                        start_q  <= 1'b1;
                    end
                end
                FRAME_Y: begin
                    if (frame_done) begin
                        hold_y_q <= frame_result;
                        state_q  <= UPDATE;
                    end
                end
                UPDATE: begin
                    x_q     <= hold_x_q;
                    y_q     <= hold_y_q;
                    new_q   <= 1'b1;
                    gap_q   <= '0;
                    state_q <= GAP;
                end
                GAP: begin
                    if (gap_q != GAP_SAT) gap_q <= gap_q + 1'b1;
                    if (gap_q >= GAP_END) begin
                        if (!pen_s2_q) begin
                            state_q <= FRAME_X;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign new_coord_r = new_q;
    assign penirq_n    = penirq_q;
    assign transmit_en = tx_q;

endmodule

// File: doc/touch_adc_ctrl.md
TOUCH_ADC_CTRL -- requirements
Module: touch_adc_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 16: sys_clk cycles per adc_dclk half-period; legal range 2..255.
REQ-002 Parameter GAP_CYC, default 4096: idle sys_clk cycles between successive X/Y pairs while the pen is down.
REQ-003 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-004 iRST_n  in  1  asynchronous, active-low reset.
REQ-005 adc_penirq_n  in  1  raw pen-interrupt from the ADC; low = pen down; asynchronous.
REQ-006 adc_dout  in  1  ADC serial data out; asynchronous.
REQ-007 adc_busy  in  1  ADC busy; monitored only, no function.
REQ-008 adc_cs_n  out  1  ADC chip select, active low.
REQ-009 adc_dclk  out  1  ADC serial clock.
REQ-010 adc_din  out  1  ADC serial command data.
REQ-011 x, y  out  8 each  last completed X and Y conversion results.
REQ-012 new_coord_r  out  1  one-cycle pulse when x and y have both been updated.
REQ-013 penirq_n  out  1  synchronized, frozen pen-interrupt for the touch interpreter.
REQ-014 transmit_en  out  1  high for the whole pen-down session, from the first frame until the pen is released.

Function
REQ-015 adc_penirq_n and adc_dout shall each pass through a 2-flop synchronizer before use.
REQ-016 penirq_n shall follow the synchronized adc_penirq_n while adc_cs_n is high, and shall hold its last value while adc_cs_n is low.
REQ-017 FSM states: IDLE, FRAME_X, FRAME_Y, UPDATE, GAP.
REQ-018 IDLE -> FRAME_X when synchronized pen is low; transmit_en rises in that same cycle.
REQ-019 Each frame: adc_cs_n low, then 24 adc_dclk periods, then adc_cs_n high for 2*CLK_DIV cycles before the next state.
REQ-020 adc_dclk idles low; adc_din changes on falling adc_dclk; the ADC samples on rising adc_dclk.
REQ-021 Frame bits 1-8 shift a command MSB-first: X = 8'hD8, Y = 8'h98 (8-bit mode, differential, power-down between conversions); bits 9-24 drive adc_din = 0.
REQ-022 Synchronized adc_dout shall be sampled on rising adc_dclk of periods 10-17, MSB first, into an 8-bit result.
REQ-023 FRAME_X stores its result in a holding register; FRAME_Y stores its result likewise; x and y do not change during FRAME_X or FRAME_Y.
REQ-024 UPDATE lasts one cycle: x and y load from the holding registers simultaneously and new_coord_r pulses for exactly that cycle; next state is GAP.
REQ-025 GAP counts GAP_CYC cycles, then -> FRAME_X if pen is low, otherwise -> IDLE with transmit_en low.
REQ-026 Pen release during FRAME_X or FRAME_Y shall not abort the frame; the X/Y pair completes, UPDATE occurs, and release is evaluated at the end of GAP.
REQ-027 Frame timing counters shall be sized for CLK_DIV and the 24-bit count without wrap; the GAP counter shall saturate at GAP_CYC.

Reset
REQ-028 iRST_n low shall immediately force: state IDLE; adc_cs_n = 1; adc_dclk = 0; adc_din = 0; x = y = 0; new_coord_r = 0; transmit_en = 0; penirq_n = 1; all counters and synchronizers cleared (penirq synchronizer preset to 1).
REQ-029 Reset asserted mid-frame shall end the frame within the same cycle with no further adc_dclk edge; after deassertion the block restarts from IDLE.

Structure
REQ-030 Shared package touch_pkg: FSM state enum, CMD_X = 8'hD8, CMD_Y = 8'h98, FRAME_LEN = 24, DATA_FIRST = 10, DATA_LAST = 17.
REQ-031 One sub-module, touch_spi_frame: generates one 24-clock frame from a start pulse and a command byte, and returns the 8-bit result plus a done pulse; touch_adc_ctrl contains the FSM, the synchronizers, and the output registers.

Verification
REQ-032 ADC model returns 8'hA5 for X and 8'h3C for Y, pen held low -> first UPDATE gives x = A5, y = 3C; new_coord_r high for exactly one cycle; transmit_en high from the first FSM cycle.
REQ-033 CLK_DIV = 16 -> adc_dclk period is 32 sys_clk; 24 dclk periods per frame; adc_din bit pattern 11011000 for X and 10011000 for Y.
REQ-034 Pen released during FRAME_Y -> pair completes, new_coord_r pulses once, transmit_en falls at the end of GAP, FSM returns to IDLE.
REQ-035 adc_penirq_n toggles while adc_cs_n is low -> penirq_n does not change until adc_cs_n returns high.
REQ-036 iRST_n asserted at dclk period 12 of FRAME_X -> adc_cs_n = 1, adc_dclk = 0, x = y = 0 with no clock; after release with pen down, a full new pair is produced.
REQ-037 Pen held for 3 GAP intervals -> exactly 3 new_coord_r pulses, spaced by GAP_CYC plus two frame lengths.
